// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divider.
//   master (EX side)   : drives start/signed/annul/operands, observes busy/ready/results
//   slave  (div_unit)  : the reverse
// Signals:
//   start_i     divide request, held by EX until ready_o is seen
//   signed_i    1 = DIV (two's complement), 0 = DIVU
//   annul_i     flush/exception kill of the current request
//   dividend_i  numerator (rs)
//   divisor_i   denominator (rt)
//   busy_o      combinational stall request
//   ready_o     one-cycle result-valid pulse
//   quotient_o  quotient (to LO)
//   remainder_o remainder (to HI)
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic              signed_i;
  logic              annul_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic              busy_o;
  logic              ready_o;
  logic [DATA_W-1:0] quotient_o;
  logic [DATA_W-1:0] remainder_o;

  modport master (
    output start_i, signed_i, annul_i, dividend_i, divisor_i,
    input  busy_o, ready_o, quotient_o, remainder_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, dividend_i, divisor_i,
    output busy_o, ready_o, quotient_o, remainder_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider (DIV / DIVU) for the execute stage.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    div_unit_if.slave (request, stall, result handshake)
// One quotient bit is produced per CALC cycle on operand magnitudes; signs are
// applied on the last iteration. Divide-by-zero bypasses CALC and returns
// all-ones / raw dividend. Annul drops the request without touching results.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  div_unit_if.slave   bus
);
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] rem_q;   // partial remainder
  logic [DATA_W-1:0] dvd_q;   // dividend shifts out MSB-first, quotient shifts in
  logic [DATA_W-1:0] dsr_q;   // divisor magnitude
  logic              neg_quo_q, neg_rem_q;
  logic [DATA_W-1:0] quo_res_q, rem_res_q;

  logic              go, dsr_zero, last;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_nx, dvd_nx;
  logic              dvd_neg, dsr_neg;

  assign go       = bus.start_i & ~bus.annul_i;
  assign dsr_zero = (bus.divisor_i == '0);
  assign last     = (cnt_q == CW'(DATA_W - 1));
  assign dvd_neg  = bus.signed_i & bus.dividend_i[DATA_W-1];
  assign dsr_neg  = bus.signed_i & bus.divisor_i[DATA_W-1];

  // Trial subtract on DATA_W+1 bits; bit DATA_W set means it went negative.
  // rem_q < dsr_q always holds, so the restored shift never overflows DATA_W.
  assign trial  = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dsr_q};
  assign rem_nx = trial[DATA_W] ? {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]}
                                : trial[DATA_W-1:0];
  assign dvd_nx = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = dsr_zero ? DONE : CALC;
      CALC: begin
        if (bus.annul_i) state_d = IDLE;
        else if (last)   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            if (dsr_zero) begin
              quo_res_q <= '1;
              rem_res_q <= bus.dividend_i;
            end else begin
              dvd_q     <= dvd_neg ? -bus.dividend_i : bus.dividend_i;
              dsr_q     <= dsr_neg ? -bus.divisor_i  : bus.divisor_i;
              neg_quo_q <= dvd_neg ^ dsr_neg;
              neg_rem_q <= dvd_neg;
              rem_q     <= '0;
              cnt_q     <= '0;
            end
          end
        end
        CALC: begin
          if (!bus.annul_i) begin
            rem_q <= rem_nx;
            dvd_q <= dvd_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              quo_res_q <= neg_quo_q ? -dvd_nx : dvd_nx;
              rem_res_q <= neg_rem_q ? -rem_nx : rem_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = ((state_q == IDLE) & go & ~dsr_zero) | (state_q == CALC);
  // An annul landing in DONE kills the pulse but leaves the registered result.
  assign bus.ready_o     = (state_q == DONE) & ~bus.annul_i;
  assign bus.quotient_o  = quo_res_q;
  assign bus.remainder_o = rem_res_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  localparam int W = 32;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  div_unit_if #(.DATA_W(W)) bus();
  div_unit #(.DATA_W(W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    string        nm;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] held_q = '0;   // model of the result registers
  logic [W-1:0] held_r = '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every ready_o pulse must match the oldest expected result.
  initial begin
    exp_t e;
    logic prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i && bus.ready_o === 1'b1) begin
        chk("ready_single_pulse", {31'b0, prev_rdy}, '0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: q=%h r=%h with nothing outstanding",
                   bus.quotient_o, bus.remainder_o);
        end else begin
          e = sb_q.pop_front();
          chk({e.nm, "_quotient"},  bus.quotient_o,  e.q);
          chk({e.nm, "_remainder"}, bus.remainder_o, e.r);
        end
      end
      prev_rdy = (!rst_i) && (bus.ready_o === 1'b1);
    end
  end

  // Issue one divide, hold start until ready, check stall length and latency.
  // Operands are scrambled after the sampling edge; they must be ignored.
  task automatic run_div(input string nm, input logic sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input int exp_busy, input int exp_lat);
    int busy_n, lat;
    sb_q.push_back('{q: eq, r: er, nm: nm});
    @(posedge clk_i); #1;
    bus.start_i = 1'b1; bus.signed_i = sg; bus.dividend_i = a; bus.divisor_i = b;
    busy_n = 0;
    lat    = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_i);
      if (bus.busy_o) busy_n++;
      if (bus.ready_o) begin
        lat = k;
        break;
      end
      if (k == 2) begin
        bus.dividend_i = ~a;
        bus.divisor_i  = b ^ 32'h5;
        bus.signed_i   = ~sg;
      end
    end
    bus.start_i = 1'b0;
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ready within 60 cycles, expected at sample %0d", nm, exp_lat);
      void'(sb_q.pop_back());
    end else begin
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_busy_cycles"}, busy_n, exp_busy);
      held_q = eq;
      held_r = er;
    end
  endtask

  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (bus.ready_o) cnt++;
    end
  endtask

  initial begin
    int rc;
    rst_i          = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.annul_i    = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_quotient",  bus.quotient_o,  '0);
    chk("rst_remainder", bus.remainder_o, '0);
    chk("rst_busy",  {31'b0, bus.busy_o},  '0);
    chk("rst_ready", {31'b0, bus.ready_o}, '0);
    rst_i = 1'b0;

    // name, signed, dividend, divisor, quotient, remainder, busy cycles, ready sample
    run_div("divu_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 34);
    run_div("div_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33, 34);
    run_div("div_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33, 34);
    run_div("div_ovf",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33, 34);
    run_div("divu_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33, 34);
    run_div("divu_big_max",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33, 34);
    run_div("divu_by0",      1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  0,  2);
    run_div("div_by0_neg",   1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  0,  2);
    run_div("divu_100_7_b",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 34);

    // Annul mid-CALC: no result, outputs keep the previous one.
    @(posedge clk_i); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    repeat (11) @(posedge clk_i);
    #1;
    bus.annul_i = 1'b1;
    @(posedge clk_i); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    chk("annul_busy_dropped", {31'b0, bus.busy_o}, '0);
    count_ready(40, rc);
    chk("annul_no_ready", rc, 0);
    chk("annul_keep_q", bus.quotient_o,  held_q);
    chk("annul_keep_r", bus.remainder_o, held_r);
    run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33, 34);

    // Annul in DONE: pulse suppressed, registered result still lands.
    @(posedge clk_i); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'h55; bus.divisor_i = 32'd0;
    @(posedge clk_i); #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk_i);
    chk("done_annul_ready", {31'b0, bus.ready_o}, '0);
    chk("done_annul_q", bus.quotient_o,  32'hFFFF_FFFF);
    chk("done_annul_r", bus.remainder_o, 32'h55);
    @(posedge clk_i); #1;
    bus.annul_i = 1'b0;
    held_q = 32'hFFFF_FFFF;
    held_r = 32'h55;

    // Async reset mid-CALC, between edges.
    @(posedge clk_i); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
    repeat (8) @(posedge clk_i);
    #2;
    bus.start_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("arst_quotient",  bus.quotient_o,  '0);
    chk("arst_remainder", bus.remainder_o, '0);
    chk("arst_busy", {31'b0, bus.busy_o}, '0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    count_ready(40, rc);
    chk("arst_no_ready", rc, 0);
    run_div("divu_5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 33, 34);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
